tick_gen: RTL
=============

# tick_gen

Parametrised clock-enable generator for the game timing chain. From the single system clock it produces a base tick at a programmable rate, plus a cascade of binary-divided ticks and matching square-wave levels. All outputs are synchronous to `clk_50m`, so downstream logic uses ticks as enables and needs no derived clocks or BUFGs. It adds runtime speed selection and deterministic pause/reset behaviour, and it feeds the floor-scroll, score and display-blink logic.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BASE_HZ`, default 8: `tick[0]` rate in Hz at `speed`=0.
- `NUM_STAGES`, default 3: number of divide-by-2 stages after the base tick.
- Derived, not overridable: `PERIOD` = `CLK_HZ`/`BASE_HZ`; `CNT_W` = clog2(`PERIOD`).
- Legal parameters: `CLK_HZ` % `BASE_HZ` == 0, `PERIOD`>>3 ≥ 2, `NUM_STAGES` ≥ 1. Any other setting is an elaboration error.

Ports:
- `clk_50m`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: reset. Synchronous, active-high.
- `pause`, in, 1: freezes the counter and suppresses all ticks while high.
- `speed`, in, 2: rate multiplier. Effective period `P_eff` = `PERIOD` >> `speed` (×1, ×2, ×4, ×8).
- `tick`, out, `NUM_STAGES`+1: one-cycle enable pulses. Bit k fires at `BASE_HZ`·2^`speed`/2^k.
- `level`, out, `NUM_STAGES`+1: square waves. Bit k toggles on each `tick[k]`, so 50% duty.

## Operation
- State:
  - base counter `cnt` (`CNT_W` bits);
  - latched speed `spd_q` (2 bits);
  - cascade counter `div_q` (`NUM_STAGES` bits);
  - registered `tick` and `level`.
- Reset (`rst`=1 at an edge):
  - `cnt`=0, `div_q`=0, `tick`=0, `level`=0;
  - `spd_q` loads `speed`.
  - Reset dominates `pause` and every other condition.
- Run (`rst`=0, `pause`=0):
  - If `cnt` == `P_eff`−1 (wrap):
    - `cnt` ← 0;
    - `spd_q` ← `speed`;
    - `tick[0]` ← 1 and `level[0]` toggles;
    - `div_q` ← `div_q`+1 (wraps modulo 2^`NUM_STAGES`);
    - for k ≥ 1: `tick[k]` ← 1 and `level[k]` toggles iff `div_q` bits [k−1:0] are all ones before the increment.
  - Otherwise: `cnt` ← `cnt`+1 and all `tick` bits ← 0.
- Pause (`rst`=0, `pause`=1):
  - `cnt`, `div_q`, `spd_q` and `level` hold; all `tick` ← 0.
  - A wrap due during pause is dropped, not deferred. The period resumes from the held `cnt` value.
- Speed change:
  - `speed` is sampled only at wrap and at reset.
  - A mid-period change never truncates or extends the current period.
  - `cnt` is always 0 when `P_eff` changes, so it can never exceed the new terminal value.
- Ticks of every stage are coincident: whenever `tick[k]` is high, `tick[0..k−1]` are also high in the same cycle.

## Timing
- Reset values: `tick`=0 and `level`=0 in the first cycle after any reset edge.
- Edge numbering: edge 1 is the first edge with `rst`=0, `pause`=0.
- Base tick:
  - `tick[0]` is high during the cycle after edge `P_eff`, then every `P_eff` edges.
  - Pulse width is exactly 1 cycle. Latency from wrap detection to output is 1 register stage.
- Cascade:
  - `tick[k]` first fires after edge `P_eff`·2^k, with period `P_eff`·2^k.
  - `level[k]` has period `P_eff`·2^(k+1).
- Pause timing:
  - Pause asserted on the wrap edge: no tick, `cnt` holds at `P_eff`−1.
  - The tick fires on the first unpaused edge after pause is released.
- Reset mid-period: counting restarts from 0. No partial or stale tick is emitted after the reset edge.

## Test plan
Bench parameters: `CLK_HZ`=160, `BASE_HZ`=10, `NUM_STAGES`=3, so `PERIOD`=16.

- **Base and cascade rates.** Reset, then `speed`=0 for 256 cycles → `tick[0]` pulses 16 times at 16-cycle spacing; `tick[1]`, `tick[2]`, `tick[3]` pulse 8, 4, 2 times; `level[0]` period 32; all pulses are 1 cycle wide and coincident as specified.
- **Speed range and latching.**
  - `speed`=3 → `tick[0]` every 2 cycles.
  - Switch `speed` 0→2 at `cnt`=5 → that period still completes at 16 cycles; the next period is 4 cycles.
- **Pause.**
  - Assert `pause` at `cnt`=10 for 7 cycles → no ticks during pause; the next `tick[0]` occurs 6 unpaused cycles after release.
  - Assert `pause` exactly on the wrap edge → the tick appears only after release.
- **Reset.**
  - Assert `rst` mid-period while `level`=1111 and `pause`=1 → next cycle `tick`=0, `level`=0; first `tick[0]` 16 edges after release.
  - A `speed` value held during reset is used for the first period.
- **Cascade wrap.** Run 8 base ticks → `div_q` wraps 7→0; `tick[3]` fires on the 8th tick with all `tick` bits = 1111; no tick on the 9th beyond `tick[0]`.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen
// Clock-enable generator for the game timing chain. A base counter produces
// tick[0] at BASE_HZ * 2^speed; a cascade of divide-by-2 stages produces
// tick[1..NUM_STAGES], each half the rate of the one below it. level[k] is a
// 50% square wave that toggles on every tick[k]. Everything is synchronous to
// clk_50m, so downstream logic uses ticks as enables rather than as clocks.
//
// Ports
//   clk_50m : system clock (single domain)
//   rst     : synchronous, active-high reset; loads speed, clears all else
//   pause   : freezes counters and level, suppresses all ticks
//   speed   : rate multiplier select, period = PERIOD >> speed
//   tick    : one-cycle enable pulses, bit k at base rate / 2^k
//   level   : square waves, bit k toggles on each tick[k]
module tick_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BASE_HZ    = 8,
    parameter int NUM_STAGES = 3
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    input  logic                  pause,
    input  logic [1:0]            speed,
    output logic [NUM_STAGES:0]   tick,
    output logic [NUM_STAGES:0]   level
);

    localparam int PERIOD = CLK_HZ / BASE_HZ;
    localparam int CNT_W  = $clog2(PERIOD);

    // Terminal counts for each speed setting. PERIOD may be an exact power
    // of two, so the terminal value (not PERIOD itself) is what must fit.
    localparam logic [CNT_W-1:0] TERM_X1 = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] TERM_X2 = CNT_W'((PERIOD >> 1) - 1);
    localparam logic [CNT_W-1:0] TERM_X4 = CNT_W'((PERIOD >> 2) - 1);
    localparam logic [CNT_W-1:0] TERM_X8 = CNT_W'((PERIOD >> 3) - 1);

    // Reject parameter sets the divider cannot realise exactly.
    if (CLK_HZ % BASE_HZ != 0) begin : g_bad_ratio
        $error("tick_gen: CLK_HZ must be an integer multiple of BASE_HZ");
    end
    if ((PERIOD >> 3) < 2) begin : g_bad_period
        $error("tick_gen: PERIOD >> 3 must be at least 2");
    end
    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("tick_gen: NUM_STAGES must be at least 1");
    end

    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [1:0]            spd_q,   spd_d;
    logic [NUM_STAGES-1:0] div_q,   div_d;
    logic [NUM_STAGES:0]   tick_q,  tick_d;
    logic [NUM_STAGES:0]   level_q, level_d;

    logic [CNT_W-1:0] term;
    logic             wrap;
    logic             all_ones;

    // Terminal count follows the latched speed, never the live input, so a
    // mid-period speed change cannot shorten or stretch the current period.
    always_comb begin
        term = TERM_X1;
        case (spd_q)
            2'd0:    term = TERM_X1;
            2'd1:    term = TERM_X2;
            2'd2:    term = TERM_X4;
            default: term = TERM_X8;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        spd_d    = spd_q;
        div_d    = div_q;
        tick_d   = '0;
        level_d  = level_q;
        wrap     = 1'b0;
        all_ones = 1'b1;

        if (!pause) begin
            wrap = (cnt_q == term);
            if (wrap) begin
                cnt_d = '0;
                spd_d = speed;
                div_d = div_q + NUM_STAGES'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Stage k fires when every lower divider bit is about to carry,
            // which keeps all stage ticks coincident with tick[0].
            tick_d[0] = wrap;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                all_ones  = all_ones & div_q[k-1];
                tick_d[k] = wrap & all_ones;
            end

            level_d = level_q ^ tick_d;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q   <= '0;
            spd_q   <= speed;
            div_q   <= '0;
            tick_q  <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            spd_q   <= spd_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;

endmodule
